// File: rtl/demux_stream_1xn_if.sv
// Stream bus for demux_stream_1xn: one input stream fanned out to N output slots.
// The in_bcast wire exists only when DEMUX_BCAST_EN is defined.
interface demux_stream_1xn_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 16
) ();
  localparam int unsigned N = 2 ** SEL_W;

  logic [DATA_W-1:0]   I;
  logic [SEL_W-1:0]    sel;
  logic                in_valid;
  logic                in_ready;
`ifdef DEMUX_BCAST_EN
  logic                in_bcast;
`endif
  logic [N*DATA_W-1:0] y;
  logic [N-1:0]        y_valid;
  logic [N-1:0]        y_ready;
  logic [CNT_W-1:0]    acc_cnt;

  modport master (
    output I, sel, in_valid, y_ready,
`ifdef DEMUX_BCAST_EN
    output in_bcast,
`endif
    input  in_ready, y, y_valid, acc_cnt
  );

  modport slave (
    input  I, sel, in_valid, y_ready,
`ifdef DEMUX_BCAST_EN
    input  in_bcast,
`endif
    output in_ready, y, y_valid, acc_cnt
  );
endinterface

// File: rtl/demux_stream_1xn.sv
// 1-to-N stream demux with one registered slot per channel and an accept counter.
// Define DEMUX_BCAST_EN to add in_bcast, which loads the word into every slot at once.
module demux_stream_1xn #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  demux_stream_1xn_if.slave  bus
);
  localparam int unsigned N = 2 ** SEL_W;

  logic [N-1:0]        full_q, full_d;
  logic [N*DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [N-1:0] drain;
  logic [N-1:0] sel_oh;
  logic [N-1:0] load;
  logic         sel_ready;
  logic         accept;

  assign drain     = full_q & bus.y_ready;
  assign sel_oh    = N'(1) << bus.sel;
  assign sel_ready = !full_q[bus.sel] || bus.y_ready[bus.sel];

`ifdef DEMUX_BCAST_EN
  logic all_ready;
  assign all_ready    = &(~full_q | bus.y_ready);
  assign bus.in_ready = bus.in_bcast ? all_ready : sel_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = !accept ? '0 : (bus.in_bcast ? '1 : sel_oh);
`else
  assign bus.in_ready = sel_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept ? sel_oh : '0;
`endif

  // A refill wins over a drain so the slot stays valid with no bubble.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (load[k]) begin
        full_d[k]                  = 1'b1;
        data_d[k*DATA_W +: DATA_W] = bus.I;
      end else if (drain[k]) begin
        full_d[k]                  = 1'b0;
        data_d[k*DATA_W +: DATA_W] = '0;
      end
    end
    cnt_d = cnt_q + CNT_W'(accept);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.y       = data_q;
  assign bus.y_valid = full_q;
  assign bus.acc_cnt = cnt_q;
endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: directed vector table, corner sequences, and random
// traffic checked against a per-channel slot model.
module tb_demux_stream_1xn;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_stream_1xn_if #(.DATA_W(8), .SEL_W(3), .CNT_W(16)) bus ();
  demux_stream_1xn #(.DATA_W(8), .SEL_W(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each channel is a one-word mailbox.
  bit         mfull[N];
  logic [7:0] mdata[N];
  int         mcnt;
  bit         bcast;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_rdy();
    if (bcast) begin
      for (int k = 0; k < N; k++) if (mfull[k] && !bus.y_ready[k]) return 1'b0;
      return 1'b1;
    end
    return !mfull[bus.sel] || bus.y_ready[bus.sel];
  endfunction

  function automatic logic [7:0] m_yv();
    logic [7:0] v;
    for (int k = 0; k < N; k++) v[k] = mfull[k];
    return v;
  endfunction

  function automatic logic [63:0] m_y();
    logic [63:0] v;
    for (int k = 0; k < N; k++) v[k*8 +: 8] = mfull[k] ? mdata[k] : 8'h00;
    return v;
  endfunction

  task automatic drive(logic [7:0] i, logic [2:0] s, bit v, logic [7:0] yr, bit b);
    bus.I        = i;
    bus.sel      = s;
    bus.in_valid = v;
    bus.y_ready  = yr;
    bcast        = b;
`ifdef DEMUX_BCAST_EN
    bus.in_bcast = b;
`endif
  endtask

  // One clock: optionally check in_ready before the edge and all outputs after it.
  task automatic tick(bit chk);
    bit acc;
    #1;
    acc = bus.in_valid && m_rdy();
    if (chk) check("in_ready", 64'(bus.in_ready), 64'(m_rdy()));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        mfull[k] = 1'b0;
        mdata[k] = 8'h00;
      end
      mcnt = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (acc && (bcast || int'(bus.sel) == k)) begin
          mfull[k] = 1'b1;
          mdata[k] = bus.I;
        end else if (mfull[k] && bus.y_ready[k]) begin
          mfull[k] = 1'b0;
        end
      end
      if (acc) mcnt = (mcnt + 1) % 65536;
    end
    if (chk) begin
      check("y_valid", 64'(bus.y_valid), 64'(m_yv()));
      check("y", bus.y, m_y());
      check("acc_cnt", 64'(bus.acc_cnt), 64'(mcnt));
    end
  endtask

  typedef struct {
    logic [7:0]  i;
    logic [2:0]  s;
    bit          v;
    logic [7:0]  yr;
    bit          rdy;
    logic [7:0]  yv;
    logic [63:0] y;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{8'hA5, 3'd3, 1'b1, 8'h00, 1'b1, 8'h08, 64'h0000_0000_A500_0000, 16'd1};
    tbl[1] = '{8'h77, 3'd3, 1'b1, 8'h00, 1'b0, 8'h08, 64'h0000_0000_A500_0000, 16'd1};
    tbl[2] = '{8'h66, 3'd5, 1'b1, 8'h00, 1'b1, 8'h28, 64'h0000_6600_A500_0000, 16'd2};
    tbl[3] = '{8'h3C, 3'd3, 1'b1, 8'h08, 1'b1, 8'h28, 64'h0000_6600_3C00_0000, 16'd3};
    tbl[4] = '{8'h11, 3'd2, 1'b0, 8'h00, 1'b1, 8'h28, 64'h0000_6600_3C00_0000, 16'd3};
    tbl[5] = '{8'h00, 3'd0, 1'b0, 8'h20, 1'b1, 8'h08, 64'h0000_0000_3C00_0000, 16'd3};
    tbl[6] = '{8'h00, 3'd0, 1'b0, 8'h08, 1'b1, 8'h00, 64'h0000_0000_0000_0000, 16'd3};

    drive(8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick(1'b0);
    rst_n = 1'b1;
    check("rst_y_valid", 64'(bus.y_valid), 64'h0);
    check("rst_y", bus.y, 64'h0);
    check("rst_acc_cnt", 64'(bus.acc_cnt), 64'h0);

    foreach (tbl[n]) begin
      drive(tbl[n].i, tbl[n].s, tbl[n].v, tbl[n].yr, 1'b0);
      #1;
      check($sformatf("vec%0d_in_ready", n), 64'(bus.in_ready), 64'(tbl[n].rdy));
      tick(1'b0);
      check($sformatf("vec%0d_y_valid", n), 64'(bus.y_valid), 64'(tbl[n].yv));
      check($sformatf("vec%0d_y", n), bus.y, tbl[n].y);
      check($sformatf("vec%0d_acc_cnt", n), 64'(bus.acc_cnt), 64'(tbl[n].cnt));
    end

    // Fill every slot, then reset with a word in flight: nothing survives.
    for (int k = 0; k < N; k++) begin
      drive(8'(k * 16 + 1), 3'(k), 1'b1, 8'h00, 1'b0);
      tick(1'b1);
    end
    check("all_full", 64'(bus.y_valid), 64'hFF);
    drive(8'hEE, 3'd1, 1'b1, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick(1'b1);
    rst_n = 1'b1;
    check("rst2_y_valid", 64'(bus.y_valid), 64'h0);
    check("rst2_y", bus.y, 64'h0);
    check("rst2_acc_cnt", 64'(bus.acc_cnt), 64'h0);
    drive(8'h42, 3'd0, 1'b1, 8'h00, 1'b0);
    tick(1'b1);
    check("post_rst_y_valid", 64'(bus.y_valid), 64'h01);
    check("post_rst_y", bus.y, 64'h42);

`ifdef DEMUX_BCAST_EN
    rst_n = 1'b0;
    tick(1'b0);
    rst_n = 1'b1;
    drive(8'h99, 3'd2, 1'b1, 8'h00, 1'b0);
    tick(1'b1);
    drive(8'h5A, 3'd6, 1'b1, 8'h00, 1'b1);
    #1;
    check("bcast_blocked", 64'(bus.in_ready), 64'h0);
    tick(1'b1);
    drive(8'h5A, 3'd6, 1'b1, 8'h04, 1'b1);
    #1;
    check("bcast_ready", 64'(bus.in_ready), 64'h1);
    tick(1'b1);
    check("bcast_y_valid", 64'(bus.y_valid), 64'hFF);
    check("bcast_y", bus.y, 64'h5A5A_5A5A_5A5A_5A5A);
    check("bcast_acc_cnt", 64'(bus.acc_cnt), 64'd2);
`endif

    // Random traffic with occasional resets.
    rst_n = 1'b0;
    tick(1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      bit b;
`ifdef DEMUX_BCAST_EN
      b = ($urandom_range(0, 3) == 0);
`else
      b = 1'b0;
`endif
      drive(8'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom), b);
      rst_n = ($urandom_range(0, 59) != 0);
      tick(1'b1);
    end
    rst_n = 1'b1;

    // Counter wrap: every cycle accepts because all consumers are ready.
    for (int c = 0; c < 70000 && mcnt != 65535; c++) begin
      drive(8'($urandom), 3'($urandom), 1'b1, 8'hFF, 1'b0);
      tick(1'b0);
    end
    check("cnt_at_max", 64'(bus.acc_cnt), 64'hFFFF);
    drive(8'h01, 3'd4, 1'b1, 8'hFF, 1'b0);
    tick(1'b1);
    check("cnt_wrap", 64'(bus.acc_cnt), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_stream_1xn.md
DEMUX_STREAM_1XN -- requirements
Module: demux_stream_1xn

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the data path.
REQ-002 SHALL have parameter SEL_W, default 3, select width; channel count N = 2**SEL_W (default 8).
REQ-003 SHALL have parameter CNT_W, default 16, width of the accepted-transfer counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port I  input  DATA_W  input data word.
REQ-007 SHALL have port sel  input  SEL_W  destination channel index.
REQ-008 SHALL have port in_valid  input  1  I/sel valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts I this cycle.
REQ-010 SHALL have port y  output  N*DATA_W  channel k data on y[k*DATA_W +: DATA_W].
REQ-011 SHALL have port y_valid  output  N  channel k holds a word.
REQ-012 SHALL have port y_ready  input  N  channel k consumer takes word.
REQ-013 SHALL have port acc_cnt  output  CNT_W  count of accepted input transfers.

Function
REQ-014 SHALL hold one registered slot per channel: full flag (drives y_valid[k]) and data register (drives y slice k).
REQ-015 SHALL define accept = in_valid && in_ready; drain[k] = y_valid[k] && y_ready[k].
REQ-016 SHALL drive in_ready combinationally = !y_valid[sel] || y_ready[sel] (non-broadcast).
REQ-017 SHALL, on accept in cycle t, present I on slot sel with y_valid[sel]=1 from cycle t+1 (latency 1).
REQ-018 SHALL, on drain[k] without refill of k, clear y_valid[k] and zero slot k data next cycle; unselected/empty channels always output 0.
REQ-019 SHALL, on drain[k] and refill of k in same cycle, load new word with y_valid[k] held 1 (no bubble, no loss).
REQ-020 SHALL treat channels independently: drain of channel j never affects slot k != j.
REQ-021 SHALL hold slot contents stable while y_valid[k]=1 and y_ready[k]=0.
REQ-022 SHALL ignore I and sel when in_valid=0; no slot changes.
REQ-023 SHALL increment acc_cnt by 1 per accept, wrapping from 2**CNT_W-1 to 0; broadcast accept counts as 1.
REQ-024 SHALL contain no combinational path from I to y.

Reset
REQ-025 SHALL, when rst_n=0 at a rising clk edge, clear all y_valid, all y data, and acc_cnt to 0.
REQ-026 SHALL drive in_ready from post-reset state only; words held or in flight at reset are discarded, not delivered.
REQ-027 SHALL resume normal acceptance on the first edge with rst_n=1.

Configuration
REQ-028 SHALL support macro DEMUX_BCAST_EN.
REQ-029 SHALL, with DEMUX_BCAST_EN defined, add port in_bcast input 1; when in_bcast=1, sel is ignored and in_ready = AND over k of (!y_valid[k] || y_ready[k]).
REQ-030 SHALL, on broadcast accept, load I into all N slots and set all y_valid next cycle.
REQ-031 SHALL, without DEMUX_BCAST_EN, omit in_bcast and all broadcast logic; behaviour per REQ-016..REQ-023 only.

Verification
REQ-032 SHALL cover: reset, then I=8'hA5, sel=3, in_valid=1, y_ready=0 -> cycle t+1 y_valid=8'h08, y slice 3=8'hA5, all other slices 0, acc_cnt=1.
REQ-033 SHALL cover: slot 3 full, y_ready[3]=0, new word sel=3 -> in_ready=0, slot 3 keeps 8'hA5; same cycle sel=5 -> in_ready=1, slot 5 loads.
REQ-034 SHALL cover: slot 3 full, y_ready[3]=1, I=8'h3C sel=3 -> in_ready=1, next cycle slot 3=8'h3C, y_valid[3] stays 1.
REQ-035 SHALL cover: acc_cnt at 16'hFFFF, one accept -> acc_cnt=16'h0000.
REQ-036 SHALL cover: slots 0..7 full, rst_n=0 one edge -> y_valid=0, y=0, acc_cnt=0, next word sel=0 accepted.
REQ-037 SHALL cover (DEMUX_BCAST_EN): in_bcast=1, I=8'h5A, slot 2 full with y_ready[2]=0 -> in_ready=0; release y_ready[2] -> all 8 slots 8'h5A next cycle, acc_cnt +1.
